// File: rtl/digit_scan_if.sv
// Handshake bundle between a digit scan controller and its host.
// With SCAN_SKIP_EN defined the bundle also carries the per-digit enable mask.
interface digit_scan_if;
    logic        en;
    logic        load;
    logic [15:0] data_in;
`ifdef SCAN_SKIP_EN
    logic [3:0]  mask;
`endif
    logic [1:0]  sel;
    logic        sel_valid;
    logic [3:0]  nibble;
    logic        frame_tick;

`ifdef SCAN_SKIP_EN
    modport master (
        output en, load, data_in, mask,
        input  sel, sel_valid, nibble, frame_tick
    );
    modport slave (
        input  en, load, data_in, mask,
        output sel, sel_valid, nibble, frame_tick
    );
`else
    modport master (
        output en, load, data_in,
        input  sel, sel_valid, nibble, frame_tick
    );
    modport slave (
        input  en, load, data_in,
        output sel, sel_valid, nibble, frame_tick
    );
`endif
endinterface

// File: rtl/digit_scan_ctrl.sv
// Four-digit display scan controller with dead-time blanking and frame-synchronous double buffering.
// Define SCAN_SKIP_EN to add a per-digit enable mask that skips disabled digits.
module digit_scan_ctrl #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned DEAD     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    digit_scan_if.slave bus
);

    localparam int unsigned CMAX = (PRESCALE > DEAD) ? PRESCALE : DEAD;
    localparam int unsigned CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    sel_q;
    logic          valid_q;
    logic          tick_q;
    logic [3:0]    nibble_q;

    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          flag_q, flag_d;

    logic [3:0]    mask_w;
    logic [1:0]    first_sel;
    logic [1:0]    next_sel;
    logic          wrap;
    logic          act_end;
    logic          blank_end;
    logic          frame_edge;
    logic          commit;

    function automatic logic [3:0] pick(input logic [15:0] d, input logic [1:0] s);
        return d[{s, 2'b00} +: 4];
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else if (m[3]) r = 2'd3;
        else           r = 2'd0;
        return r;
    endfunction

    // Walks forward from s; a lone enabled digit returns s itself.
    function automatic logic [1:0] next_en(input logic [1:0] s, input logic [3:0] m);
        logic [1:0] c;
        logic [1:0] r;
        logic       found;
        c     = s;
        r     = s;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            c = c + 2'd1;
            if (!found && m[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef SCAN_SKIP_EN
    assign mask_w = bus.mask;
`else
    assign mask_w = 4'b1111;
`endif

    assign first_sel  = lowest(mask_w);
    assign next_sel   = next_en(sel_q, mask_w);
    assign wrap       = (next_sel <= sel_q);
    assign act_end    = (state_q == ACTIVE) && (cnt_q == CW'(PRESCALE - 1));
    assign blank_end  = (state_q == BLANK) && (cnt_q == CW'(DEAD - 1));
    assign frame_edge = bus.en && act_end && wrap && (mask_w != '0);
    assign commit     = (state_q == IDLE) || frame_edge;

    // A load landing on a commit cycle bypasses pending and goes straight to display.
    always_comb begin
        disp_d = disp_q;
        pend_d = pend_q;
        flag_d = flag_q;
        if (commit) begin
            if (bus.load) begin
                disp_d = bus.data_in;
            end else if (flag_q) begin
                disp_d = pend_q;
            end
            flag_d = 1'b0;
        end else if (bus.load) begin
            pend_d = bus.data_in;
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            pend_q <= '0;
            flag_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
            pend_q <= pend_d;
            flag_q <= flag_d;
        end
    end

    // nibble is looked up from the post-commit buffer so it always matches the new sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            tick_q   <= 1'b0;
            nibble_q <= '0;
        end else begin
            tick_q   <= 1'b0;
            nibble_q <= pick(disp_d, sel_q);
            if (!bus.en) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                sel_q    <= '0;
                valid_q  <= 1'b0;
                nibble_q <= pick(disp_d, 2'd0);
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (mask_w != '0) begin
                            state_q  <= ACTIVE;
                            sel_q    <= first_sel;
                            valid_q  <= 1'b1;
                            nibble_q <= pick(disp_d, first_sel);
                        end else begin
                            sel_q    <= '0;
                            valid_q  <= 1'b0;
                            nibble_q <= pick(disp_d, 2'd0);
                        end
                    end
                    ACTIVE: begin
                        if (act_end) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            if (mask_w == '0) begin
                                state_q  <= IDLE;
                                sel_q    <= '0;
                                nibble_q <= pick(disp_d, 2'd0);
                            end else begin
                                state_q  <= BLANK;
                                sel_q    <= next_sel;
                                tick_q   <= wrap;
                                nibble_q <= pick(disp_d, next_sel);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    BLANK: begin
                        if (blank_end) begin
                            state_q <= ACTIVE;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        sel_q    <= '0;
                        valid_q  <= 1'b0;
                        nibble_q <= pick(disp_d, 2'd0);
                    end
                endcase
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_valid  = valid_q;
    assign bus.nibble     = nibble_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit display.
- Generates the 2-bit select code that drives the 2x4 one-hot decoder directly downstream.
- Presents the 4-bit data nibble for the selected digit.
- Inserts blanking dead-time between digits to suppress ghosting, and double-buffers display data so frames never tear.

Parameters:
- PRESCALE, 1000, clock cycles each digit is driven (active window); legal >= 2.
- DEAD, 4, blank cycles between digits (sel_valid low while sel changes); legal >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low forces idle.
- load  in  1  one-cycle strobe; captures data_in into the pending buffer.
- data_in  in  16  four nibbles; digit k = data_in[4k+3:4k].
- sel  out  2  digit code to the 2x4 decoder input.
- sel_valid  out  1  high while the decoded digit may be driven (ACTIVE only).
- nibble  out  4  displayed-buffer nibble for the current sel.
- frame_tick  out  1  one-cycle pulse at the end of digit 3's ACTIVE window.

Behaviour:
- Reset (rst_n low, async): sel=0, sel_valid=0, nibble=0, frame_tick=0; pending, displayed and pending flag cleared; counter=0; state IDLE.
- All outputs registered; nibble always corresponds to the sel value on the same cycle.
- IDLE: sel=0, sel_valid=0. en=1 -> ACTIVE on the next edge with sel=0, counter=0.
- ACTIVE: sel_valid=1; counter runs 0..PRESCALE-1. At PRESCALE-1 -> BLANK; counter=0; sel=sel+1 mod 4 (3 wraps to 0).
- BLANK: sel_valid=0; counter runs 0..DEAD-1, then -> ACTIVE with counter=0.
- sel changes only on the ACTIVE->BLANK edge, never while sel_valid=1.
- Digit period = PRESCALE+DEAD cycles; frame = 4*(PRESCALE+DEAD) cycles.
- frame_tick: high for exactly the one cycle following the ACTIVE->BLANK edge where sel wraps 3->0.
- en low in any state -> IDLE on the next edge: sel_valid=0, sel=0, counter=0, no frame_tick.
- Buffering:
  - load writes data_in into pending and sets the pending flag; repeated loads overwrite (last wins).
  - Commit pending->displayed only at the frame boundary (sel wrap 3->0) or on any cycle while IDLE.
  - Commit clears the flag.
  - load coincident with a commit cycle: data_in commits directly to displayed, flag stays clear.
- Reset mid-scan: immediate return to reset values; no partial frame resumes.

Optional Feature:
- Macro: SCAN_SKIP_EN.
- Defined: adds input mask (in, 4 bits, bit k=1 enables digit k).
  - ACTIVE->BLANK advances sel to the next enabled digit, wrapping modulo 4.
  - Skipped digits consume no ACTIVE or BLANK time.
  - Entry from IDLE goes to the lowest enabled digit.
  - frame_tick and commit occur when sel wraps past the highest enabled digit back to the lowest.
  - mask=0: behave as IDLE while en=1 (sel_valid=0, sel=0, commits allowed).
  - mask is sampled at each ACTIVE->BLANK edge and at IDLE exit.
  - Single enabled digit: sel is constant, but BLANK still occurs and frame_tick fires every digit period.
- Undefined: no mask port; all four digits are scanned in order 0,1,2,3.

Test Plan:
- PRESCALE=4, DEAD=2, reset then en=1 -> sel sequence 0,1,2,3,0:
  - sel_valid high 4 cycles, low 2 cycles per digit.
  - frame_tick pulses once every 24 cycles, one cycle after the 3->0 change.
- Scanning with displayed=0x0000; load data_in=0xABCD during digit 1 -> nibble stays 0 until the wrap, then digits 0..3 show D,C,B,A.
- Two loads (0x1111, then 0x2222) within one frame -> after the wrap, displayed=0x2222; 0x1111 never appears.
- load data_in=0x5A5A in the exact cycle of the 3->0 wrap -> the next frame shows 0x5A5A, and the pending flag is clear afterwards.
- en dropped mid-ACTIVE on digit 2 -> next cycle sel_valid=0, sel=0, no frame_tick. Re-enable -> restart at digit 0 with a full 4-cycle ACTIVE window.
- SCAN_SKIP_EN, mask=4'b1010 -> sel alternates 1,3,1,3 with 6-cycle digit period, frame_tick every 12 cycles. rst_n low mid-BLANK -> all outputs 0 immediately, asynchronously.
